// File: rtl/divu_if.sv
// divu_if: request/result bundle for the iterative unsigned divider.
// The CPU side drives the master modport; the divider implements the slave.
interface divu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/divu.sv
// divu: iterative restoring unsigned divider, one quotient bit per clock.
// Optional feature macro: DIVU_EARLY_OUT_EN -- when defined, a request with
// a < b (and b != 0) completes in one cycle with q=0, r=a.
module divu #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  clrn,
  divu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state,    w_state_next;
  logic [WIDTH-1:0] r_dividend, w_dividend_next;
  logic [WIDTH-1:0] r_divisor,  w_divisor_next;
  logic [WIDTH:0]   r_rem,      w_rem_next;
  logic [WIDTH-1:0] r_quot,     w_quot_next;
  logic [CW-1:0]    r_cnt,      w_cnt_next;
  logic [WIDTH-1:0] r_q,        w_q_next;
  logic [WIDTH-1:0] r_r,        w_r_next;
  logic             r_done,     w_done_next;
  logic             r_dz,       w_dz_next;

  // One restoring step: bring in the next dividend bit, try to subtract.
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_step;
  logic [WIDTH-1:0] w_quot_step;

  assign w_rem_shift = {r_rem[WIDTH-1:0], r_dividend[WIDTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_divisor};
  assign w_fits      = ~w_trial[WIDTH];
  assign w_rem_step  = w_fits ? w_trial : w_rem_shift;
  assign w_quot_step = {r_quot[WIDTH-2:0], w_fits};

  // Next-state and datapath update; everything holds unless changed below.
  always_comb begin
    w_state_next    = r_state;
    w_dividend_next = r_dividend;
    w_divisor_next  = r_divisor;
    w_rem_next      = r_rem;
    w_quot_next     = r_quot;
    w_cnt_next      = r_cnt;
    w_q_next        = r_q;
    w_r_next        = r_r;
    w_done_next     = 1'b0;
    w_dz_next       = r_dz;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_dividend_next = bus.a;
          w_divisor_next  = bus.b;
          w_rem_next      = '0;
          w_quot_next     = '0;
          w_cnt_next      = CW'(WIDTH);
          if (bus.b == '0) begin
            // Divide by zero resolves immediately without entering the loop.
            w_q_next    = '1;
            w_r_next    = bus.a;
            w_dz_next   = 1'b1;
            w_done_next = 1'b1;
`ifdef DIVU_EARLY_OUT_EN
          end else if (bus.a < bus.b) begin
            w_q_next    = '0;
            w_r_next    = bus.a;
            w_dz_next   = 1'b0;
            w_done_next = 1'b1;
`endif
          end else begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        w_dividend_next = {r_dividend[WIDTH-2:0], 1'b0};
        w_rem_next      = w_rem_step;
        w_quot_next     = w_quot_step;
        w_cnt_next      = r_cnt - CW'(1);
        // The step that takes the counter to zero publishes the result.
        if (r_cnt == CW'(1)) begin
          w_q_next     = w_quot_step;
          w_r_next     = w_rem_step[WIDTH-1:0];
          w_dz_next    = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_dividend <= w_dividend_next;
      r_divisor  <= w_divisor_next;
      r_rem      <= w_rem_next;
      r_quot     <= w_quot_next;
      r_cnt      <= w_cnt_next;
      r_q        <= w_q_next;
      r_r        <= w_r_next;
      r_done     <= w_done_next;
      r_dz       <= w_dz_next;
    end
  end

  assign bus.q        = r_q;
  assign bus.r        = r_r;
  assign bus.busy     = (r_state == RUN);
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_divu.sv
// tb_divu: self-checking bench for divu against an arithmetic reference
// (q = a/b, r = a%b, divide-by-zero gives all ones and a).
module tb_divu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  divu_if #(.WIDTH(W)) bus ();

  divu #(.WIDTH(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one divide and follow it to done. Returns just after the done edge,
  // so a following call starts in the done cycle (back-to-back).
  // intrude: pulse a 5/5 request at E3 which must be ignored.
  task automatic do_div(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit intrude);
    logic [W-1:0] exp_q, exp_r;
    logic         exp_dz;
    int           exp_lat, n;
    bit           busy_bad;
    if (tb_v == 0) begin
      exp_q = '1; exp_r = ta; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = ta / tb_v; exp_r = ta % tb_v; exp_dz = 1'b0; exp_lat = W;
`ifdef DIVU_EARLY_OUT_EN
      if (ta < tb_v) exp_lat = 0;
`endif
    end
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
    n = 0; busy_bad = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy !== (exp_lat != 0)) busy_bad = 1;
      if (intrude && n == 2) begin bus.start = 1'b1; bus.a = 5; bus.b = 5; end
      @(posedge clk); #1;
      if (intrude && n == 2) bus.start = 1'b0;
      n++;
    end
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0d after %0d edges", ta, tb_v, bus.q, bus.r, bus.div_zero, n);
    check("latency", n, exp_lat);
    check("busy_during", busy_bad, 0);
    check("busy_at_done", bus.busy, 0);
    check("q", bus.q, exp_q);
    check("r", bus.r, exp_r);
    check("div_zero", bus.div_zero, exp_dz);
  endtask

  // One idle edge after a completion: done drops, results hold.
  task automatic check_hold(input logic [W-1:0] hq, input logic [W-1:0] hr, input logic hdz);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("hold_q", bus.q, hq);
    check("hold_r", bus.r, hr);
    check("hold_dz", bus.div_zero, hdz);
  endtask

  initial begin
    bit seen_done;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    clrn = 1'b1;
    @(posedge clk); #1;

    do_div(100, 7, 0);
    check_hold(14, 2, 0);

    do_div(255, 1, 0);
    do_div(0, 9, 0);
    check_hold(0, 0, 0);

    do_div(77, 0, 0);
    do_div(9, 3, 0);
    check_hold(3, 0, 0);

    do_div(200, 13, 1);
    check_hold(15, 5, 0);

    do_div(5, 9, 0);
    do_div(255, 255, 0);
    do_div(254, 255, 0);

    // Reset mid-operation: started at E0, clrn asserted just after E4.
    bus.start = 1'b1; bus.a = 100; bus.b = 7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check("abort_q", bus.q, 0);
    check("abort_r", bus.r, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1;
    end
    check("no_done_after_abort", seen_done, 0);

    // Random mix, some back-to-back, some with idle gaps, some b=0.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      do_div(ra, rb, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check("rand_done_pulse", bus.done, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
